serial_receiver: RTL and testbench
==================================

SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, word width in bits (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port serial_in  input  1  serial bit from upstream shifter, MSB first; may be high-Z when enable is low.
REQ-005 SHALL have port enable  input  1  bit-valid strobe; serial_in sampled only when high.
REQ-006 SHALL have port start  input  1  frame-start pulse; aligns bit counter.
REQ-007 SHALL have port ready_in  input  1  downstream accepts data_out when high with valid_out.
REQ-008 SHALL have port data_out  output  DATA_WIDTH  assembled word, held stable while valid_out high.
REQ-009 SHALL have port valid_out  output  1  data_out holds an unconsumed word.
REQ-010 SHALL have port busy  output  1  high in SHIFT state.
REQ-011 SHALL have port overrun  output  1  sticky; a completed word was dropped.
REQ-012 SHALL have port parity_err  output  1  sticky; parity mismatch seen (tied 0 without parity feature).

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT (plus PARITY when feature compiled in).
REQ-014 IDLE: start=1 -> SHIFT with bit count cleared; enable ignored in IDLE unless start also high.
REQ-015 start and enable high in same cycle SHALL capture serial_in as bit 1 of the new frame.
REQ-016 SHIFT: each enable=1 cycle SHALL shift buffer left, serial_in into LSB, count +1; enable=0 holds state.
REQ-017 On the DATA_WIDTH-th bit (no parity), buffer content including that bit SHALL transfer to data_out next edge, valid_out=1, FSM -> IDLE; latency one cycle after last bit.
REQ-018 start=1 during SHIFT SHALL discard the partial word and restart at count 0 (count 1 if enable also high).
REQ-019 valid_out SHALL clear on the edge where valid_out and ready_in are both high, unless a new word completes that same edge.
REQ-020 Word completing while valid_out high and ready_in low SHALL be dropped, data_out unchanged, overrun set.
REQ-021 Word completing on the same edge as a handshake SHALL load data_out, keep valid_out=1, no overrun.
REQ-022 Bit counter SHALL be ceil(log2(DATA_WIDTH+2)) bits wide and never wrap past terminal count.
REQ-023 overrun and parity_err SHALL clear only on reset.

Reset
REQ-024 reset=1 SHALL asynchronously force IDLE, count 0, buffer 0, data_out 0, valid_out 0, busy 0, overrun 0, parity_err 0, mid-frame included.
REQ-025 First start SHALL be honoured on the first rising edge after reset deasserts.

Configuration
REQ-026 Macro SERIAL_RECEIVER_PARITY_EN SHALL add one even-parity bit after the DATA_WIDTH data bits.
REQ-027 With macro: FSM enters PARITY after last data bit; on parity bit, match -> word delivered per REQ-017/020/021, mismatch -> word discarded, parity_err set.
REQ-028 Without macro: no PARITY state, parity_err constant 0, word delivered after DATA_WIDTH bits.

Structure
REQ-029 Package serial_pkg SHALL hold FSM state typedef/encoding, default DATA_WIDTH constant and counter-width function.
REQ-030 Bit counter SHALL be a sub-module bit_counter (clear, increment, terminal-count flag).

Verification
REQ-031 start, then 8 enabled bits 1,0,1,1,0,0,1,0, ready_in=1 -> data_out=8'hB2, valid_out one cycle, overrun 0.
REQ-032 Same frame with enable gaps of 3 cycles between bits, serial_in=Z in gaps -> data_out=8'hB2.
REQ-033 Word 8'h5A held (ready_in=0), second frame 8'hFF completes -> data_out stays 8'h5A, overrun=1.
REQ-034 Restart: start, 4 bits, start again, 8 bits of 8'h3C -> data_out=8'h3C only.
REQ-035 reset asserted after 5 bits -> all outputs 0 immediately; subsequent frame 8'h81 received correctly.
REQ-036 With SERIAL_RECEIVER_PARITY_EN: 8'h81 with parity 0 -> delivered; with parity 1 -> valid_out stays 0, parity_err=1.

Source files
------------

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared FSM encoding and sizing helpers for serial_receiver (PARITY state only with SERIAL_RECEIVER_PARITY_EN)
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

`ifdef SERIAL_RECEIVER_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1
    } state_t;
`endif

    // Wide enough to hold every data bit plus the parity slot without wrapping.
    function automatic int cnt_width(input int data_width);
        return $clog2(data_width + 2);
    endfunction

endpackage

// File: rtl/bit_counter.sv
// rtl/bit_counter.sv - saturating frame bit counter with terminal-count flag
module bit_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam logic [WIDTH-1:0] TERM = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count;

    assign tc = (count == TERM);

    // Clear with a simultaneous increment lands on 1; counting stops one past TERM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count <= TERM)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// rtl/serial_receiver.sv - MSB-first serial-to-parallel receiver with valid/ready output; SERIAL_RECEIVER_PARITY_EN adds even parity
module serial_receiver
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  serial_in,
    input  logic                  enable,
    input  logic                  start,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic                  overrun,
    output logic                  parity_err
);

    localparam int CNT_W = cnt_width(DATA_WIDTH);

    state_t                state_q;
    state_t                state_d;
    logic [DATA_WIDTH-1:0] buffer;
    logic                  cnt_clear;
    logic                  cnt_inc;
    logic                  last_bit;
    logic                  shift_en;
    logic                  word_done;
    logic                  word_ready;
`ifdef SERIAL_RECEIVER_PARITY_EN
    logic                  parity_bad;
`endif

    bit_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (DATA_WIDTH - 1)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .tc    (last_bit)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_clear = 1'b0;
        cnt_inc   = 1'b0;
        shift_en  = 1'b0;
        word_done = 1'b0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        parity_bad = 1'b0;
`endif
        // start wins in every state: it both opens a frame and abandons a partial one.
        if (start) begin
            state_d   = SHIFT;
            cnt_clear = 1'b1;
            cnt_inc   = enable;
            shift_en  = enable;
        end else begin
            case (state_q)
                SHIFT: begin
                    if (enable) begin
                        cnt_inc  = 1'b1;
                        shift_en = 1'b1;
                        if (last_bit) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                            state_d = PARITY;
`else
                            state_d   = IDLE;
                            word_done = 1'b1;
`endif
                        end
                    end
                end
`ifdef SERIAL_RECEIVER_PARITY_EN
                PARITY: begin
                    if (enable) begin
                        state_d = IDLE;
                        if (serial_in == ^buffer) begin
                            word_done = 1'b1;
                        end else begin
                            parity_bad = 1'b1;
                        end
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy = (state_q == SHIFT);

    // A finished word sits in buffer for one cycle (word_ready) before the output handshake sees it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer     <= '0;
            data_out   <= '0;
            valid_out  <= 1'b0;
            overrun    <= 1'b0;
            word_ready <= 1'b0;
        end else begin
            word_ready <= word_done;
            if (cnt_clear) begin
                buffer <= {{(DATA_WIDTH-1){1'b0}}, shift_en & serial_in};
            end else if (shift_en) begin
                buffer <= {buffer[DATA_WIDTH-2:0], serial_in};
            end
            if (word_ready) begin
                if (!valid_out || ready_in) begin
                    data_out  <= buffer;
                    valid_out <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

`ifdef SERIAL_RECEIVER_PARITY_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_err <= 1'b0;
        end else if (parity_bad) begin
            parity_err <= 1'b1;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_receiver.sv
// tb/tb_serial_receiver.sv - randomized and directed bench for serial_receiver against a frame-level model (honours SERIAL_RECEIVER_PARITY_EN)
module tb_serial_receiver;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         serial_in;
    logic         enable;
    logic         start;
    logic         ready_in;
    logic [W-1:0] data_out;
    logic         valid_out;
    logic         busy;
    logic         overrun;
    logic         parity_err;

    int vectors;
    int miscompares;

    // Model state: phase 0 = no frame, 1 = collecting data, 2 = awaiting parity.
    int          m_phase;
    int          m_nbits;
    int unsigned m_val;
    bit          m_pend;
    int unsigned m_pword;
    logic [W-1:0] m_dout;
    bit          m_valid;
    bit          m_ovr;
    bit          m_perr;
`ifdef SERIAL_RECEIVER_PARITY_EN
    bit          bad_parity;
`endif

    serial_receiver #(.DATA_WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .enable     (enable),
        .start      (start),
        .ready_in   (ready_in),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .busy       (busy),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_nbits = 0; m_val = 0;
        m_pend = 0; m_pword = 0;
        m_dout = '0; m_valid = 0; m_ovr = 0; m_perr = 0;
    endfunction

    function automatic void model_edge(input bit s, input bit e, input bit b, input bit r);
        bit          np;
        int unsigned nw;
        np = 0;
        nw = 0;
        if (m_pend) begin
            if (!m_valid || r) begin
                m_dout  = m_pword[W-1:0];
                m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
        if (s) begin
            m_phase = 1;
            m_nbits = e ? 1 : 0;
            m_val   = e ? b : 0;
        end else if (e && m_phase == 1) begin
            m_val = m_val * 2 + b;
            m_nbits++;
            if (m_nbits == W) begin
`ifdef SERIAL_RECEIVER_PARITY_EN
                m_phase = 2;
`else
                m_phase = 0;
                np = 1;
                nw = m_val;
`endif
            end
        end else if (e && m_phase == 2) begin
            m_phase = 0;
            if (int'(b) == ($countones(m_val) % 2)) begin
                np = 1;
                nw = m_val;
            end else begin
                m_perr = 1;
            end
        end
        m_pend  = np;
        m_pword = nw;
    endfunction

    task automatic compare_all();
        check_eq("data_out", data_out, m_dout);
        check_eq("valid_out", valid_out, m_valid);
        check_eq("busy", busy, m_phase == 1);
        check_eq("overrun", overrun, m_ovr);
        check_eq("parity_err", parity_err, m_perr);
    endtask

    task automatic step(input bit s, input bit e, input bit b, input bit r);
        start     = s;
        enable    = e;
        serial_in = e ? b : 1'bz;
        ready_in  = r;
        @(posedge clk);
        model_edge(s, e, b, r);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        start = 0; enable = 0; serial_in = 1'bz; ready_in = 0;
        reset = 1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int gap, input bit r);
        step(1, 0, 0, r);
        for (int i = W - 1; i >= 0; i--) begin
            step(0, 1, w[i], r);
            if (i > 0) repeat (gap) step(0, 0, 0, r);
        end
`ifdef SERIAL_RECEIVER_PARITY_EN
        repeat (gap) step(0, 0, 0, r);
        step(0, 1, (^w) ^ bad_parity, r);
`endif
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
`ifdef SERIAL_RECEIVER_PARITY_EN
        bad_parity = 0;
`endif
        reset = 1;
        do_reset();
        check_eq("reset_valid", valid_out, 0);
        check_eq("reset_data", data_out, 0);

        // Back-to-back frame with ready high: one valid cycle.
        send_word(8'hB2, 0, 1);
        step(0, 0, 0, 1);
        check_eq("b2_data", data_out, 8'hB2);
        check_eq("b2_valid", valid_out, 1);
        step(0, 0, 0, 1);
        check_eq("b2_valid_cleared", valid_out, 0);
        check_eq("b2_overrun", overrun, 0);

        // Same frame with 3-cycle enable gaps and floating serial_in.
        do_reset();
        send_word(8'hB2, 3, 1);
        step(0, 0, 0, 1);
        check_eq("gap_data", data_out, 8'hB2);

        // Held word must survive a second completed frame.
        do_reset();
        send_word(8'h5A, 0, 0);
        step(0, 0, 0, 0);
        send_word(8'hFF, 0, 0);
        step(0, 0, 0, 0);
        check_eq("ovr_data", data_out, 8'h5A);
        check_eq("ovr_flag", overrun, 1);
        check_eq("ovr_valid", valid_out, 1);

        // Restart after a partial frame.
        do_reset();
        step(1, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, 1'($urandom), 1);
        check_eq("restart_no_valid", valid_out, 0);
        send_word(8'h3C, 0, 1);
        step(0, 0, 0, 1);
        check_eq("restart_data", data_out, 8'h3C);

        // Asynchronous reset in mid-frame with a word held.
        do_reset();
        send_word(8'hA5, 0, 0);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        #1 reset = 1;
        #1;
        check_eq("areset_data", data_out, 0);
        check_eq("areset_valid", valid_out, 0);
        check_eq("areset_busy", busy, 0);
        check_eq("areset_overrun", overrun, 0);
        model_reset();
        #1 reset = 0;
        send_word(8'h81, 0, 1);
        step(0, 0, 0, 1);
        check_eq("post_reset_data", data_out, 8'h81);
        check_eq("post_reset_valid", valid_out, 1);

`ifdef SERIAL_RECEIVER_PARITY_EN
        do_reset();
        send_word(8'h81, 0, 1);
        step(0, 0, 0, 1);
        check_eq("par_good_valid", valid_out, 1);
        check_eq("par_good_data", data_out, 8'h81);
        step(0, 0, 0, 1);
        bad_parity = 1;
        send_word(8'h81, 0, 1);
        bad_parity = 0;
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check_eq("par_bad_valid", valid_out, 0);
        check_eq("par_bad_err", parity_err, 1);
`endif

        // Random traffic with periodic resets so the sticky flags get re-exercised.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 400 == 399) do_reset();
            step(($urandom % 16) == 0, 1'($urandom), 1'($urandom), ($urandom % 3) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
